// File: rtl/ni_flit_injector.sv
// Network-interface flit injector: turns core-side packet requests and data words into
// HEADER/PAYLOAD/TAIL flits under credit flow control. Optional NI_PKT_CNT_EN adds pkt_cnt.
module ni_flit_injector #(
   parameter int DATA_W    = 32,
   parameter int LEN_W     = 4,
   parameter int BUF_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        cur_addr_rst,
   input  logic              pkt_valid,
   output logic              pkt_ready,
   input  logic [3:0]        pkt_dst,
   input  logic [LEN_W-1:0]  pkt_len,
   input  logic              data_valid,
   output logic              data_ready,
   input  logic [DATA_W-1:0] data_in,
   input  logic              credit_in,
   output logic              flit_valid,
   output logic [2:0]        flit_id,
   output logic [3:0]        dst_addr,
   output logic [DATA_W-1:0] flit_data,
   output logic              err_len,
   output logic              err_credit
`ifdef NI_PKT_CNT_EN
   ,
   output logic [15:0]       pkt_cnt
`endif
);

   localparam logic [2:0] FLIT_HEADER  = 3'b001;
   localparam logic [2:0] FLIT_PAYLOAD = 3'b010;
   localparam logic [2:0] FLIT_TAIL    = 3'b100;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HEAD = 2'd1;
   localparam logic [1:0] S_BODY = 2'd2;
   localparam logic [1:0] S_TAIL = 2'd3;

   localparam int CW = 4;
   localparam logic [CW-1:0] FULL_CREDITS = CW'(BUF_DEPTH);

   logic [1:0]       state;
   logic [3:0]       src_addr;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] rem;
   logic [CW-1:0]    credits;
   logic             has_credit;
   logic             pkt_acc;
   logic             data_acc;
   logic             send;

   assign has_credit = (credits != '0);
   assign pkt_ready  = (state == S_IDLE) && !rst;
   assign data_ready = ((state == S_BODY) || (state == S_TAIL)) && has_credit && !rst;
   assign pkt_acc    = pkt_valid && pkt_ready;
   assign data_acc   = data_valid && data_ready;
   assign send       = ((state == S_HEAD) && has_credit) || data_acc;

   // Only the registered credit count gates sending; credit_in takes effect next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         src_addr   <= cur_addr_rst;
         dst_addr   <= '0;
         len_q      <= '0;
         rem        <= '0;
         credits    <= FULL_CREDITS;
         flit_valid <= 1'b0;
         flit_id    <= '0;
         flit_data  <= '0;
         err_len    <= 1'b0;
         err_credit <= 1'b0;
`ifdef NI_PKT_CNT_EN
         pkt_cnt    <= '0;
`endif
      end else begin
         flit_valid <= send;
         err_len    <= pkt_acc && (pkt_len == '0);

         case (state)
            S_IDLE: begin
               if (pkt_acc && (pkt_len != '0)) begin
                  dst_addr <= pkt_dst;
                  len_q    <= pkt_len;
                  rem      <= pkt_len;
                  state    <= S_HEAD;
               end
            end
            S_HEAD: begin
               if (has_credit) begin
                  flit_id   <= FLIT_HEADER;
                  flit_data <= {{(DATA_W-8-LEN_W){1'b0}}, src_addr, dst_addr, len_q};
                  state     <= (len_q == LEN_W'(1)) ? S_TAIL : S_BODY;
               end
            end
            S_BODY: begin
               if (data_acc) begin
                  flit_id   <= FLIT_PAYLOAD;
                  flit_data <= data_in;
                  rem       <= rem - LEN_W'(1);
                  if (rem == LEN_W'(2))
                     state <= S_TAIL;
               end
            end
            S_TAIL: begin
               if (data_acc) begin
                  flit_id   <= FLIT_TAIL;
                  flit_data <= data_in;
                  state     <= S_IDLE;
`ifdef NI_PKT_CNT_EN
                  pkt_cnt   <= pkt_cnt + 16'd1;
`endif
               end
            end
            default: state <= S_IDLE;
         endcase

         // A credit returned while already full is a protocol error from the router.
         case ({send, credit_in})
            2'b10: credits <= credits - CW'(1);
            2'b01: begin
               if (credits == FULL_CREDITS)
                  err_credit <= 1'b1;
               else
                  credits <= credits + CW'(1);
            end
            default: credits <= credits;
         endcase
      end
   end

endmodule

// File: tb/tb_ni_flit_injector.sv
// Directed testbench for ni_flit_injector: one instance with BUF_DEPTH=4, one with BUF_DEPTH=2,
// sharing stimulus but with separate resets. Define NI_PKT_CNT_EN to also check pkt_cnt.
module tb_ni_flit_injector;

   localparam int DATA_W = 32;
   localparam int LEN_W  = 4;
   localparam logic [2:0] HEADER  = 3'b001;
   localparam logic [2:0] PAYLOAD = 3'b010;
   localparam logic [2:0] TAIL    = 3'b100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_a, rst_b;
   logic [3:0]        cur_addr_rst;
   logic              pkt_valid;
   logic [3:0]        pkt_dst;
   logic [LEN_W-1:0]  pkt_len;
   logic              data_valid;
   logic [DATA_W-1:0] data_in;
   logic              credit_in;

   logic              pkt_ready_a, data_ready_a, flit_valid_a, err_len_a, err_credit_a;
   logic [2:0]        flit_id_a;
   logic [3:0]        dst_addr_a;
   logic [DATA_W-1:0] flit_data_a;
   logic              pkt_ready_b, data_ready_b, flit_valid_b, err_len_b, err_credit_b;
   logic [2:0]        flit_id_b;
   logic [3:0]        dst_addr_b;
   logic [DATA_W-1:0] flit_data_b;
`ifdef NI_PKT_CNT_EN
   logic [15:0]       pkt_cnt_a, pkt_cnt_b;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   ni_flit_injector #(.DATA_W(DATA_W), .LEN_W(LEN_W), .BUF_DEPTH(4)) dut_a (
      .clk(clk), .rst(rst_a), .cur_addr_rst(cur_addr_rst),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready_a), .pkt_dst(pkt_dst), .pkt_len(pkt_len),
      .data_valid(data_valid), .data_ready(data_ready_a), .data_in(data_in),
      .credit_in(credit_in), .flit_valid(flit_valid_a), .flit_id(flit_id_a),
      .dst_addr(dst_addr_a), .flit_data(flit_data_a),
      .err_len(err_len_a), .err_credit(err_credit_a)
`ifdef NI_PKT_CNT_EN
      , .pkt_cnt(pkt_cnt_a)
`endif
   );

   ni_flit_injector #(.DATA_W(DATA_W), .LEN_W(LEN_W), .BUF_DEPTH(2)) dut_b (
      .clk(clk), .rst(rst_b), .cur_addr_rst(cur_addr_rst),
      .pkt_valid(pkt_valid), .pkt_ready(pkt_ready_b), .pkt_dst(pkt_dst), .pkt_len(pkt_len),
      .data_valid(data_valid), .data_ready(data_ready_b), .data_in(data_in),
      .credit_in(credit_in), .flit_valid(flit_valid_b), .flit_id(flit_id_b),
      .dst_addr(dst_addr_b), .flit_data(flit_data_b),
      .err_len(err_len_b), .err_credit(err_credit_b)
`ifdef NI_PKT_CNT_EN
      , .pkt_cnt(pkt_cnt_b)
`endif
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic pv, input logic [3:0] dst, input logic [LEN_W-1:0] len,
                                input logic dv, input logic [DATA_W-1:0] din, input logic cr);
      pkt_valid  = pv;
      pkt_dst    = dst;
      pkt_len    = len;
      data_valid = dv;
      data_in    = din;
      credit_in  = cr;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkFlitA(input string tag, input logic [2:0] id, input logic [DATA_W-1:0] d);
      checkOutput({tag, "_valid"}, 64'(flit_valid_a), 64'(1'b1));
      checkOutput({tag, "_id"},    64'(flit_id_a),    64'(id));
      checkOutput({tag, "_data"},  64'(flit_data_a),  64'(d));
   endtask

   task automatic checkFlitB(input string tag, input logic [2:0] id, input logic [DATA_W-1:0] d);
      checkOutput({tag, "_valid"}, 64'(flit_valid_b), 64'(1'b1));
      checkOutput({tag, "_id"},    64'(flit_id_b),    64'(id));
      checkOutput({tag, "_data"},  64'(flit_data_b),  64'(d));
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      cur_addr_rst = 4'h5;
      applyStimulus(1'b0, 4'h0, '0, 1'b0, '0, 1'b0);
      repeat (2) tick;
      checkOutput("rst_pkt_ready",  64'(pkt_ready_a),   64'(0));
      checkOutput("rst_flit_valid", 64'(flit_valid_a),  64'(0));
      checkOutput("rst_data_ready", 64'(data_ready_a),  64'(0));
      checkOutput("rst_err_len",    64'(err_len_a),     64'(0));
      checkOutput("rst_err_credit", 64'(err_credit_a),  64'(0));
      checkOutput("rst_dst_addr",   64'(dst_addr_a),    64'(0));
      checkOutput("rst_credits",    64'(dut_a.credits), 64'(4));
      rst_a = 1'b0;
      #1;
      checkOutput("idle_pkt_ready", 64'(pkt_ready_a), 64'(1));

      $display("[TB] len=3 packet to 0xA");
      applyStimulus(1'b1, 4'hA, 4'd3, 1'b1, 32'h11, 1'b0);
      tick;
      checkOutput("t1_no_flit_yet", 64'(flit_valid_a), 64'(0));
      checkOutput("t1_busy",        64'(pkt_ready_a),  64'(0));
      applyStimulus(1'b0, 4'h0, '0, 1'b1, 32'h11, 1'b0);
      tick;
      checkFlitA("t1_header", HEADER, 32'h0000_05A3);
      checkOutput("t1_dst_h", 64'(dst_addr_a), 64'(4'hA));
      tick;
      checkFlitA("t1_pay1", PAYLOAD, 32'h11);
      applyStimulus(1'b0, 4'h0, '0, 1'b1, 32'h22, 1'b0);
      tick;
      checkFlitA("t1_pay2", PAYLOAD, 32'h22);
      applyStimulus(1'b0, 4'h0, '0, 1'b1, 32'h33, 1'b0);
      tick;
      checkFlitA("t1_tail", TAIL, 32'h33);
      checkOutput("t1_dst_t",     64'(dst_addr_a),    64'(4'hA));
      checkOutput("t1_credits",   64'(dut_a.credits), 64'(0));
      checkOutput("t1_pkt_ready", 64'(pkt_ready_a),   64'(1));
      checkOutput("t1_dready",    64'(data_ready_a),  64'(0));
      applyStimulus(1'b0, 4'h0, '0, 1'b0, '0, 1'b1);
      tick;
      checkOutput("t1_after_tail", 64'(flit_valid_a), 64'(0));
      repeat (3) tick;
      applyStimulus(1'b0, 4'h0, '0, 1'b0, '0, 1'b0);
      checkOutput("t1_credits_back", 64'(dut_a.credits), 64'(4));
      checkOutput("t1_no_err_cr",    64'(err_credit_a),  64'(0));

      $display("[TB] len=1 packet to 0x0");
      applyStimulus(1'b1, 4'h0, 4'd1, 1'b1, 32'h77, 1'b0);
      tick;
      applyStimulus(1'b0, 4'h0, '0, 1'b1, 32'h77, 1'b0);
      tick;
      checkFlitA("t2_header", HEADER, 32'h0000_0501);
      checkOutput("t2_busy", 64'(pkt_ready_a), 64'(0));
      tick;
      checkFlitA("t2_tail", TAIL, 32'h77);
      checkOutput("t2_pkt_ready", 64'(pkt_ready_a), 64'(1));
      applyStimulus(1'b0, 4'h0, '0, 1'b0, '0, 1'b1);
      tick;
      checkOutput("t2_no_payload", 64'(flit_valid_a), 64'(0));
      tick;
      applyStimulus(1'b0, 4'h0, '0, 1'b0, '0, 1'b0);
      checkOutput("t2_credits_back", 64'(dut_a.credits), 64'(4));

      $display("[TB] zero-length request and credit overflow");
      applyStimulus(1'b1, 4'h7, 4'd0, 1'b1, 32'h99, 1'b0);
      tick;
      checkOutput("t5_err_len",    64'(err_len_a),    64'(1));
      checkOutput("t5_no_flit",    64'(flit_valid_a), 64'(0));
      checkOutput("t5_still_idle", 64'(pkt_ready_a),  64'(1));
      applyStimulus(1'b0, 4'h0, '0, 1'b0, '0, 1'b0);
      tick;
      checkOutput("t5_err_len_pulse", 64'(err_len_a),    64'(0));
      checkOutput("t5_no_flit2",      64'(flit_valid_a), 64'(0));
      applyStimulus(1'b0, 4'h0, '0, 1'b0, '0, 1'b1);
      tick;
      applyStimulus(1'b0, 4'h0, '0, 1'b0, '0, 1'b0);
      checkOutput("t5_err_credit",  64'(err_credit_a),  64'(1));
      checkOutput("t5_credits_hold", 64'(dut_a.credits), 64'(4));
      tick;
      checkOutput("t5_err_sticky", 64'(err_credit_a), 64'(1));

      $display("[TB] reset in the middle of a len=5 packet");
      applyStimulus(1'b1, 4'hC, 4'd5, 1'b1, 32'h100, 1'b0);
      tick;
      applyStimulus(1'b0, 4'h0, '0, 1'b1, 32'h100, 1'b0);
      tick;
      checkFlitA("t6_header", HEADER, 32'h0000_05C5);
      tick;
      checkFlitA("t6_pay1", PAYLOAD, 32'h100);
      rst_a = 1'b1;
      #1;
      checkOutput("t6_dready_in_rst", 64'(data_ready_a), 64'(0));
      tick;
      checkOutput("t6_rst_flit",    64'(flit_valid_a),  64'(0));
      checkOutput("t6_rst_credits", 64'(dut_a.credits), 64'(4));
      checkOutput("t6_rst_err_cr",  64'(err_credit_a),  64'(0));
      checkOutput("t6_rst_ready",   64'(pkt_ready_a),   64'(0));
      rst_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         checkOutput("t6_no_flit", 64'(flit_valid_a), 64'(0));
      end
      checkOutput("t6_idle", 64'(pkt_ready_a), 64'(1));
`ifdef NI_PKT_CNT_EN
      checkOutput("t6_cnt_zero", 64'(pkt_cnt_a), 64'(0));
`endif
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1'b1, 4'h1, 4'd1, 1'b1, 32'hA0 + 32'(k), 1'b0);
         tick;
         applyStimulus(1'b0, 4'h0, '0, 1'b1, 32'hA0 + 32'(k), 1'b0);
         tick;
         checkFlitA("t6_hdr", HEADER, 32'h0000_0511);
         tick;
         checkFlitA("t6_tail", TAIL, 32'hA0 + 32'(k));
      end
`ifdef NI_PKT_CNT_EN
      checkOutput("t6_cnt_two", 64'(pkt_cnt_a), 64'(2));
`endif

      $display("[TB] BUF_DEPTH=2 stall and credit return");
      rst_a = 1'b1;
      applyStimulus(1'b0, 4'h0, '0, 1'b0, '0, 1'b0);
      tick;
      rst_b = 1'b0;
      #1;
      checkOutput("t3_idle",    64'(pkt_ready_b),   64'(1));
      checkOutput("t3_credits", 64'(dut_b.credits), 64'(2));
      applyStimulus(1'b1, 4'h3, 4'd4, 1'b1, 32'hB1, 1'b0);
      tick;
      applyStimulus(1'b0, 4'h0, '0, 1'b1, 32'hB1, 1'b0);
      tick;
      checkFlitB("t3_header", HEADER, 32'h0000_0534);
      tick;
      checkFlitB("t3_pay1", PAYLOAD, 32'hB1);
      checkOutput("t3_out_of_credit", 64'(data_ready_b), 64'(0));
      applyStimulus(1'b0, 4'h0, '0, 1'b1, 32'hB2, 1'b0);
      for (int i = 0; i < 2; i++) begin
         tick;
         checkOutput("t3_stall_flit",   64'(flit_valid_b), 64'(0));
         checkOutput("t3_stall_dready", 64'(data_ready_b), 64'(0));
      end
      applyStimulus(1'b0, 4'h0, '0, 1'b1, 32'hB2, 1'b1);
      tick;
      applyStimulus(1'b0, 4'h0, '0, 1'b1, 32'hB2, 1'b0);
      checkOutput("t3_one_later_flit", 64'(flit_valid_b), 64'(0));
      checkOutput("t3_dready_back",    64'(data_ready_b), 64'(1));
      tick;
      checkFlitB("t3_pay2", PAYLOAD, 32'hB2);

      $display("[TB] credit return coinciding with a send");
      applyStimulus(1'b0, 4'h0, '0, 1'b1, 32'hB3, 1'b1);
      tick;
      checkOutput("t4_dready", 64'(data_ready_b), 64'(1));
      checkOutput("t4_idle_cycle", 64'(flit_valid_b), 64'(0));
      tick;
      applyStimulus(1'b0, 4'h0, '0, 1'b1, 32'hB4, 1'b0);
      checkFlitB("t4_pay3", PAYLOAD, 32'hB3);
      checkOutput("t4_credits_held", 64'(dut_b.credits), 64'(1));
      tick;
      checkFlitB("t4_tail", TAIL, 32'hB4);
      checkOutput("t4_credits_end", 64'(dut_b.credits), 64'(0));
      checkOutput("t4_pkt_ready",   64'(pkt_ready_b),   64'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
